disp_vram_rdctrl: RTL and testbench
===================================

DISP_VRAM_RDCTRL -- requirements
Module: disp_vram_rdctrl

Interface
REQ-001 SHALL have parameter H_PIX, default 640, active pixels per line.
REQ-002 SHALL have parameter V_PIX, default 480, active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16, AXI read beats per burst (64-bit beats).
REQ-004 SHALL have one clock and synchronous active-high reset: ACLK input 1 clock; ARST input 1 reset.
REQ-005 SHALL have port VRSTART, input, 1 bit: frame-start pulse, already in ACLK domain.
REQ-006 SHALL have port DISPON, input, 1 bit: display enable.
REQ-007 SHALL have port DISPADDR, input, 29 bits: frame base byte address, 128-byte aligned.
REQ-008 SHALL have port BUF_WREADY, input, 1 bit: FIFO can accept one burst.
REQ-009 SHALL have AXI read-address ports: ARADDR output 32, ARLEN output 8, ARVALID output 1, ARREADY input 1.
REQ-010 SHALL have AXI read-data ports: RDATA input 64, RLAST input 1, RVALID input 1, RREADY output 1.
REQ-011 SHALL have FIFO-side ports: FIFOIN output 64, FIFOWR output 1, FIFORST output 1.
REQ-012 SHALL have port OVERRUN, output, 1 bit: sticky flag, VRSTART arrived while busy.

Function
REQ-013 SHALL move each frame as NBURST = H_PIX*V_PIX/(2*BURST_LEN) bursts; ARADDR starts at {3'b0,DISPADDR} and advances by BURST_LEN*8 bytes per burst.
REQ-014 SHALL drive ARLEN constant BURST_LEN-1.
REQ-015 SHALL implement states IDLE, FRST, WAITBUF, ADDR, DATA.
REQ-016 IDLE: on VRSTART=1 and DISPON=1, SHALL latch DISPADDR, load the burst counter with NBURST, and go to FRST (macro on) or WAITBUF (macro off).
REQ-017 WAITBUF: when BUF_WREADY=1, SHALL go to ADDR with ARVALID=1 on the next cycle.
REQ-018 ADDR: ARVALID and ARADDR SHALL hold stable until ARREADY=1; the handshake cycle SHALL move the FSM to DATA.
REQ-019 DATA: RREADY SHALL be 1.
REQ-020 In DATA, each RVALID&RREADY beat SHALL produce FIFOWR=1 with FIFOIN=RDATA, registered, exactly 1 cycle later.
REQ-021 On the RLAST beat, SHALL advance the address and decrement the burst counter.
REQ-022 After RLAST, if the counter reaches 0, SHALL go to IDLE; otherwise SHALL go to WAITBUF.
REQ-023 RRESP SHALL be ignored.
REQ-024 DISPON falling mid-frame: an issued burst SHALL complete all beats, including the FIFO writes; the FSM SHALL then go to IDLE, and no new ARVALID SHALL be raised.
REQ-025 VRSTART outside IDLE SHALL NOT restart the frame; it SHALL set OVERRUN=1, and OVERRUN SHALL clear only when DISPON=0 or ARST=1.
REQ-026 VRSTART in the same cycle as the final RLAST SHALL count as busy: OVERRUN set, no restart.
REQ-027 At most one AXI read SHALL be outstanding; ARVALID SHALL be 0 in DATA.

Reset
REQ-028 ARST SHALL act synchronously and SHALL force: state IDLE, ARVALID=0, RREADY=0, FIFOWR=0, FIFORST=0, OVERRUN=0, ARADDR=0, FIFOIN=0, counters 0.
REQ-029 ARST mid-burst SHALL abandon the burst with no further FIFOWR; system reset also resets the interconnect.

Configuration
REQ-030 With macro DISP_FIFORST_EN defined, state FRST SHALL drive FIFORST=1 for exactly 8 cycles, then hold FIFORST=0 for 8 more cycles before entering WAITBUF.
REQ-031 Without DISP_FIFORST_EN, the FRST state and its counter SHALL be absent, FIFORST SHALL be constant 0, and IDLE SHALL go directly to WAITBUF.

Structure
REQ-032 Package disp_pkg SHALL hold the state enum, BURST_BYTES = BURST_LEN*8, the FRST timing constant 8, and H_PIX/V_PIX defaults.
REQ-033 Sub-module disp_rdaddr_gen SHALL own the address register and burst counter (load, advance, last-burst flag); the FSM and beat path SHALL stay in the top module.

Verification
REQ-034 Directed test: H_PIX=32, V_PIX=2, BURST_LEN=16, DISPADDR=0x0100000, ARREADY/RVALID always 1, BUF_WREADY=1, VRSTART pulse -> exactly 2 bursts at ARADDR 0x0100000 and 0x0100080, ARLEN=15, 32 FIFOWR pulses, FSM returns to IDLE.
REQ-035 Directed test: BUF_WREADY=0 for 50 cycles after the first burst -> ARVALID stays 0 for those 50 cycles; second burst issues 1 cycle after BUF_WREADY rises.
REQ-036 Directed test: ARREADY delayed 5 cycles -> ARVALID and ARADDR stay stable for all 6 cycles.
REQ-037 Directed test: RVALID gapped on alternate cycles -> FIFOWR count 16 per burst, with data order and values equal to RDATA.
REQ-038 Directed test: VRSTART issued mid-frame -> OVERRUN=1 and burst sequence unchanged; then DISPON=0 -> the current burst completes, FSM goes to IDLE, OVERRUN=0.
REQ-039 Directed test: with DISP_FIFORST_EN defined -> FIFORST high for 8 cycles starting 1 cycle after VRSTART, and the first ARVALID no earlier than 17 cycles after VRSTART.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display VRAM read controller.
// The FRST state exists only when DISP_FIFORST_EN is defined.
package disp_pkg;

`ifdef DISP_FIFORST_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FRST    = 3'd1,
        WAITBUF = 3'd2,
        ADDR    = 3'd3,
        DATA    = 3'd4
    } disp_state_e;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITBUF = 3'd2,
        ADDR    = 3'd3,
        DATA    = 3'd4
    } disp_state_e;
`endif

    localparam int DEF_H_PIX     = 640;
    localparam int DEF_V_PIX     = 480;
    localparam int DEF_BURST_LEN = 16;
    localparam int BURST_BYTES   = DEF_BURST_LEN * 8;
    localparam int FRST_CYCLES   = 8;

    // Two 32-bit pixels per 64-bit beat.
    function automatic int calc_nburst(input int h_pix, input int v_pix, input int burst_len);
        return (h_pix * v_pix) / (2 * burst_len);
    endfunction

endpackage

// File: rtl/disp_rdaddr_gen.sv
// Burst address register and remaining-burst counter for one frame.
module disp_rdaddr_gen
    import disp_pkg::*;
#(
    parameter int NBURST = 2,
    parameter int STEP   = BURST_BYTES,
    parameter int CNT_W  = 2
)(
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic [28:0] base,
    input  logic        advance,
    output logic [31:0] addr,
    output logic        last_burst
);

    logic [31:0]      addr_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            addr_reg <= {3'b000, base};
            cnt_reg  <= CNT_W'(NBURST);
        end else if (advance) begin
            addr_reg <= addr_reg + 32'(STEP);
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign addr       = addr_reg;
    assign last_burst = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/disp_vram_rdctrl.sv
// Frame-driven AXI burst reader feeding the display FIFO, one read outstanding.
// Optional FIFO reset sequence at frame start: define DISP_FIFORST_EN.
module disp_vram_rdctrl
    import disp_pkg::*;
#(
    parameter int H_PIX     = DEF_H_PIX,
    parameter int V_PIX     = DEF_V_PIX,
    parameter int BURST_LEN = DEF_BURST_LEN
)(
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        VRSTART,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    input  logic        BUF_WREADY,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic        FIFORST,
    output logic        OVERRUN
);

    localparam int NBURST        = calc_nburst(H_PIX, V_PIX, BURST_LEN);
    localparam int BURST_BYTES_P = BURST_LEN * 8;
    localparam int CNT_W         = $clog2(NBURST + 1);

    disp_state_e state_reg, state_next;
    logic        fifowr_reg;
    logic [63:0] fifoin_reg;
    logic        overrun_reg;
    logic        addr_load;
    logic        addr_adv;
    logic        last_burst;
    logic        beat_fire;

    assign beat_fire = (state_reg == DATA) && RVALID;

    disp_rdaddr_gen #(
        .NBURST (NBURST),
        .STEP   (BURST_BYTES_P),
        .CNT_W  (CNT_W)
    ) u_addr (
        .clk        (ACLK),
        .srst       (ARST),
        .load       (addr_load),
        .base       (DISPADDR),
        .advance    (addr_adv),
        .addr       (ARADDR),
        .last_burst (last_burst)
    );

`ifdef DISP_FIFORST_EN
    logic [3:0] frst_cnt_reg;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            frst_cnt_reg <= '0;
        end else if (state_reg == FRST) begin
            frst_cnt_reg <= frst_cnt_reg + 4'd1;
        end else begin
            frst_cnt_reg <= '0;
        end
    end

    // First half of FRST pulses the FIFO reset, second half lets it settle.
    assign FIFORST = (state_reg == FRST) && (frst_cnt_reg < 4'(FRST_CYCLES));
`else
    assign FIFORST = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_load  = 1'b0;
        addr_adv   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (VRSTART && DISPON) begin
                    addr_load = 1'b1;
`ifdef DISP_FIFORST_EN
                    state_next = FRST;
`else
                    state_next = WAITBUF;
`endif
                end
            end
`ifdef DISP_FIFORST_EN
            FRST: begin
                if (!DISPON) begin
                    state_next = IDLE;
                end else if (frst_cnt_reg == 4'(2 * FRST_CYCLES - 1)) begin
                    state_next = WAITBUF;
                end
            end
`endif
            WAITBUF: begin
                if (!DISPON) begin
                    state_next = IDLE;
                end else if (BUF_WREADY) begin
                    state_next = ADDR;
                end
            end
            // An address already presented must stay until accepted.
            ADDR: begin
                if (ARREADY) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (RVALID && RLAST) begin
                    addr_adv = 1'b1;
                    if (last_burst || !DISPON) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAITBUF;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            fifowr_reg  <= 1'b0;
            fifoin_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            fifowr_reg <= beat_fire;
            if (beat_fire) begin
                fifoin_reg <= RDATA;
            end
            if (!DISPON) begin
                overrun_reg <= 1'b0;
            end else if (VRSTART && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARVALID = (state_reg == ADDR);
    assign RREADY  = (state_reg == DATA);
    assign FIFOWR  = fifowr_reg;
    assign FIFOIN  = fifoin_reg;
    assign OVERRUN = overrun_reg;

endmodule

// File: tb/tb_disp_vram_rdctrl.sv
// Directed bench for disp_vram_rdctrl with an AXI slave model and a FIFO scoreboard.
// Build with DISP_FIFORST_EN defined to exercise the FIFO reset sequence.
module tb_disp_vram_rdctrl;

    localparam int H  = 32;
    localparam int V  = 2;
    localparam int BL = 16;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic        VRSTART = 1'b0;
    logic        DISPON = 1'b0;
    logic [28:0] DISPADDR = '0;
    logic        BUF_WREADY = 1'b0;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [63:0] RDATA = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [63:0] FIFOIN;
    logic        FIFOWR;
    logic        FIFORST;
    logic        OVERRUN;

    disp_vram_rdctrl #(.H_PIX(H), .V_PIX(V), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARST(ARST), .VRSTART(VRSTART), .DISPON(DISPON),
        .DISPADDR(DISPADDR), .BUF_WREADY(BUF_WREADY), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .FIFOIN(FIFOIN),
        .FIFOWR(FIFOWR), .FIFORST(FIFORST), .OVERRUN(OVERRUN)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [63:0] beat_data(input int s);
        return {32'hD000_0000 + 32'(s), (32'(s) * 32'h0101_0101) ^ 32'hA5A5_0000};
    endfunction

    // Model state: slave-side burst bookkeeping and FIFO scoreboard.
    bit          mon_en = 1'b0;
    int          r_beats_left = 0;
    int          r_seq = 0;
    logic [31:0] exp_addr = '0;
    int          ar_count = 0;
    int          wr_count = 0;
    logic [31:0] ar_log[$];
    logic [63:0] exp_q[$];
    bit          wr_pending = 1'b0;
    bit          gap_mode = 1'b0;
    bit          gap_phase = 1'b0;
    bit          prev_arvalid = 1'b0;
    bit          prev_arready = 1'b0;
    bit          prev_arst = 1'b1;
    logic [31:0] prev_araddr = '0;

    always @(negedge ACLK) begin
        if (mon_en) begin
            bit          hs;
            bit          bt;
            logic [63:0] d;
            hs = ARVALID && ARREADY;
            bt = RVALID && RREADY;
            chk("fifowr_timing", 64'(FIFOWR), 64'(wr_pending));
            if (wr_pending) begin
                d = exp_q.pop_front();
                if (FIFOWR) chk("fifoin_data", FIFOIN, d);
            end
            if (FIFOWR) wr_count++;
            chk("rready_outstanding", 64'(RREADY), 64'(r_beats_left > 0));
            chk("arvalid_in_data", 64'(ARVALID && RREADY), 64'(0));
            if (prev_arvalid && !prev_arready && !prev_arst) begin
                chk("arvalid_hold", 64'(ARVALID), 64'(1));
                chk("araddr_hold", 64'(ARADDR), 64'(prev_araddr));
            end
            if (ARVALID) begin
                chk("arlen", 64'(ARLEN), 64'(BL - 1));
                chk("araddr_seq", 64'(ARADDR), 64'(exp_addr));
            end
`ifndef DISP_FIFORST_EN
            chk("fiforst_const", 64'(FIFORST), 64'(0));
`endif
            prev_arvalid = ARVALID;
            prev_arready = ARREADY;
            prev_arst    = ARST;
            prev_araddr  = ARADDR;
            if (ARST) begin
                r_beats_left = 0;
                wr_pending   = 1'b0;
                exp_q.delete();
            end else begin
                if (hs) begin
                    $display("AR burst %0d addr=%h len=%0d t=%0t", ar_count, ARADDR, ARLEN, $time);
                    ar_log.push_back(ARADDR);
                    ar_count++;
                    exp_addr     = exp_addr + 32'(BL * 8);
                    r_beats_left = BL;
                end
                wr_pending = bt;
                if (bt) begin
                    exp_q.push_back(RDATA);
                    r_beats_left--;
                    r_seq++;
                end
            end
        end
    end

    // R channel of the slave: presents beats of the outstanding burst.
    always @(posedge ACLK) begin
        #1;
        gap_phase = ~gap_phase;
        RVALID = (r_beats_left > 0) && !(gap_mode && gap_phase);
        RDATA  = beat_data(r_seq);
        RLAST  = (r_beats_left == 1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic new_frame(input logic [28:0] base);
        DISPADDR = base;
        exp_addr = {3'b000, base};
        ar_count = 0;
        wr_count = 0;
        ar_log.delete();
    endtask

    task automatic start_frame(input logic [28:0] base);
        new_frame(base);
        VRSTART = 1'b1;
        tick();
        VRSTART = 1'b0;
    endtask

    task automatic wait_ar(input int n, input string tag);
        int k = 0;
        while (ar_count < n && k < 500) begin
            tick();
            k++;
        end
        chk({tag, "_ar_timeout"}, 64'(ar_count >= n), 64'(1));
    endtask

    task automatic wait_done(input int nb, input string tag);
        int k = 0;
        while (!(ar_count == nb && r_beats_left == 0 && !wr_pending) && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, "_done_timeout"}, 64'(k < 3000), 64'(1));
        repeat (3) tick();
    endtask

    task automatic quiet(input int n, input string tag);
        repeat (n) begin
            @(negedge ACLK);
            chk({tag, "_no_arvalid"}, 64'(ARVALID), 64'(0));
            tick();
        end
    endtask

    initial begin
        int          first_arv;
        int          frst_cnt;
        int          frst_first;
        int          frst_last;
        logic [31:0] saved;

        DISPON = 1'b1;
        BUF_WREADY = 1'b1;
        ARREADY = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        @(negedge ACLK);
        chk("rst_arvalid", 64'(ARVALID), 64'(0));
        chk("rst_rready", 64'(RREADY), 64'(0));
        chk("rst_fifowr", 64'(FIFOWR), 64'(0));
        chk("rst_fiforst", 64'(FIFORST), 64'(0));
        chk("rst_overrun", 64'(OVERRUN), 64'(0));
        chk("rst_araddr", 64'(ARADDR), 64'(0));
        chk("rst_fifoin", FIFOIN, 64'(0));
        tick();
        ARST = 1'b0;
        tick();

        // Basic frame plus frame-start latency.
        $display("TEST basic frame");
        new_frame(29'h010_0000);
        VRSTART = 1'b1;
        first_arv = -1; frst_cnt = 0; frst_first = -1; frst_last = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge ACLK);
            if (ARVALID && first_arv < 0) first_arv = k;
            if (FIFORST) begin
                frst_cnt++;
                if (frst_first < 0) frst_first = k;
                frst_last = k;
            end
            tick();
            VRSTART = 1'b0;
        end
`ifdef DISP_FIFORST_EN
        chk("fiforst_cycles", 64'(frst_cnt), 64'(8));
        chk("fiforst_first", 64'(frst_first), 64'(1));
        chk("fiforst_last", 64'(frst_last), 64'(8));
        chk("first_arvalid_ge17", 64'(first_arv >= 17), 64'(1));
`else
        chk("fiforst_cycles", 64'(frst_cnt), 64'(0));
        chk("first_arvalid_lat", 64'(first_arv), 64'(2));
`endif
        wait_done(2, "basic");
        chk("basic_bursts", 64'(ar_count), 64'(2));
        chk("basic_writes", 64'(wr_count), 64'(32));
        chk("basic_addr0", 64'(ar_log[0]), 64'(32'h0010_0000));
        chk("basic_addr1", 64'(ar_log[1]), 64'(32'h0010_0080));
        quiet(10, "basic_idle");

        // Buffer back-pressure between bursts.
        $display("TEST buf_wready stall");
        start_frame(29'h000_2000);
        wait_ar(1, "stall");
        BUF_WREADY = 1'b0;
        while (r_beats_left != 0) tick();
        quiet(50, "stall_hold");
        BUF_WREADY = 1'b1;
        @(negedge ACLK);
        chk("stall_rise_cycle", 64'(ARVALID), 64'(0));
        tick();
        @(negedge ACLK);
        chk("stall_issue_next", 64'(ARVALID), 64'(1));
        chk("stall_addr1", 64'(ARADDR), 64'(32'h0000_2080));
        tick();
        wait_done(2, "stall");
        chk("stall_writes", 64'(wr_count), 64'(32));

        // Address acceptance delayed five cycles.
        $display("TEST arready delay");
        ARREADY = 1'b0;
        start_frame(29'h0ABC_DE80);
        for (int k = 0; k < 20 && !ARVALID; k++) @(negedge ACLK);
        chk("ardly_seen", 64'(ARVALID), 64'(1));
        saved = ARADDR;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge ACLK);
            chk("ardly_valid", 64'(ARVALID), 64'(1));
            chk("ardly_addr", 64'(ARADDR), 64'(saved));
        end
        tick();
        ARREADY = 1'b1;
        @(negedge ACLK);
        chk("ardly_valid6", 64'(ARVALID), 64'(1));
        chk("ardly_addr6", 64'(ARADDR), 64'(32'h0ABC_DE80));
        tick();
        wait_done(2, "ardly");
        chk("ardly_addr1", 64'(ar_log[1]), 64'(32'h0ABC_DF00));

        // Gapped read data.
        $display("TEST rvalid gaps");
        gap_mode = 1'b1;
        start_frame(29'h000_0400);
        wait_done(2, "gap");
        chk("gap_writes", 64'(wr_count), 64'(32));
        gap_mode = 1'b0;

        // Restart attempt mid-frame, then display off.
        $display("TEST overrun and dispon off");
        start_frame(29'h004_0000);
        wait_ar(1, "ovr");
        repeat (3) tick();
        VRSTART = 1'b1;
        tick();
        VRSTART = 1'b0;
        @(negedge ACLK);
        chk("ovr_set", 64'(OVERRUN), 64'(1));
        tick();
        DISPON = 1'b0;
        wait_done(1, "ovr");
        quiet(30, "ovr_idle");
        chk("ovr_bursts", 64'(ar_count), 64'(1));
        chk("ovr_writes", 64'(wr_count), 64'(16));
        @(negedge ACLK);
        chk("ovr_clear", 64'(OVERRUN), 64'(0));
        tick();
        DISPON = 1'b1;
        tick();

        // Restart attempt on the very last beat of the frame.
        $display("TEST vrstart on final rlast");
        start_frame(29'h008_0000);
        wait_ar(2, "last");
        repeat (15) tick();
        VRSTART = 1'b1;
        @(negedge ACLK);
        chk("last_align", 64'(RVALID && RLAST && RREADY), 64'(1));
        tick();
        VRSTART = 1'b0;
        wait_done(2, "last");
        chk("last_overrun", 64'(OVERRUN), 64'(1));
        quiet(20, "last_norestart");
        chk("last_bursts", 64'(ar_count), 64'(2));
        DISPON = 1'b0;
        tick();
        DISPON = 1'b1;
        @(negedge ACLK);
        chk("last_ovr_clear", 64'(OVERRUN), 64'(0));
        tick();

        // Reset in the middle of a burst.
        $display("TEST reset mid-burst");
        start_frame(29'h00C_0000);
        wait_ar(1, "mrst");
        repeat (4) tick();
        ARST = 1'b1;
        tick();
        ARST = 1'b0;
        @(negedge ACLK);
        chk("mrst_arvalid", 64'(ARVALID), 64'(0));
        chk("mrst_rready", 64'(RREADY), 64'(0));
        chk("mrst_fifowr", 64'(FIFOWR), 64'(0));
        chk("mrst_araddr", 64'(ARADDR), 64'(0));
        chk("mrst_fifoin", FIFOIN, 64'(0));
        chk("mrst_overrun", 64'(OVERRUN), 64'(0));
        tick();
        quiet(20, "mrst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
